// File: rtl/ch3_arb_pkg.sv
// Shared types and sizes for the CH2_4MUX round-robin arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
package ch3_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ch3_rr_pick.sv
// Combinational winner picker: round-robin from last_i+1, or fixed lowest index
// when ARB_FIXED_PRIO_EN is defined.
module ch3_rr_pick
    import ch3_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        winner_o = '0;
        any_o    = |req_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) winner_o = SEL_W'(i);
        end
    end
`else
    logic [SEL_W-1:0] idx;
    logic             found;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        winner_o = '0;
        any_o    = |req_i;
        idx      = '0;
        found    = 1'b0;
        // Index arithmetic is SEL_W wide, so last_i + i wraps modulo N_REQ.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_i + SEL_W'(i);
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ch3_mux_arbiter.sv
// Arbiter/sequencer owning the CH2_4MUX select: one grant at a time, HOLD-limited,
// break-before-make, registered data output. Build macro: ARB_FIXED_PRIO_EN.
module ch3_mux_arbiter
    import ch3_arb_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] DIN,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SEL,
    output logic             Z,
    output logic             VALID,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] last_q,  last_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             z_q,     z_d;
    logic             valid_q, valid_d;

    logic [SEL_W-1:0] winner;
    logic             any_req;

    ch3_rr_pick u_pick (
        .req_i    (REQ),
        .last_i   (last_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = |gnt_q;
        z_d     = (|gnt_q) ? DIN[sel_q] : z_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(winner);
                    sel_d   = winner;
                    cnt_d   = HOLD_INIT;
                end
            end
            ST_GRANT: begin
                // Withdrawal and hold expiry on the same edge collapse into one end event.
                if (!REQ[sel_q] || cnt_q == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = sel_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            gnt_q   <= '0;
            sel_q   <= '0;
            z_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            z_q     <= z_d;
            valid_q <= valid_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign Z     = z_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == ST_GRANT);

endmodule

// File: doc/ch3_mux_arbiter.md
# ch3_mux_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit mux datapath (CH2_4MUX). Four requesters compete for the shared mux; the block grants one at a time, drives the mux select, and registers the selected bit as a qualified output stream. It sits between the requesting sources and the CH2_4MUX instance, owning its select lines.

## Interface
- HOLD, 4: maximum consecutive grant cycles per owner; legal 1..15.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- REQ  input  4  request per requester; level, held until served or withdrawn.
- DIN  input  4  mux data inputs (bit i belongs to requester i).
- GNT  output 4  one-hot grant, registered.
- SEL  output 2  mux select = index of current owner, registered.
- Z    output 1  registered selected data.
- VALID output 1  Z carries data sampled under a grant.
- BUSY output 1  high while in GRANT.

## Operation
- States: IDLE, GRANT.
- Reset (async, immediate): state IDLE, GNT=0000, SEL=00, Z=0, VALID=0, BUSY=0, hold counter=0, round-robin pointer LAST=3.
- IDLE: at each edge, if REQ!=0, winner = first set REQ bit searching LAST+1, LAST+2, ... mod 4; next cycle GNT=onehot(winner), SEL=winner, BUSY=1, counter=HOLD-1, state GRANT. If REQ=0, stay IDLE, outputs unchanged except VALID.
- GRANT: at each edge, if REQ[SEL]=0 or counter=0, end grant: GNT=0000, BUSY=0, LAST=SEL, state IDLE; SEL holds last value. Otherwise counter decrements, grant continues.
- Requests from non-owners during GRANT are ignored until IDLE; no preemption.
- Data path: every edge Z <= DIN[SEL] when GNT!=0, else Z holds; VALID <= |GNT.
- Counter is 4 bits, never wraps: saturates at 0, grant ends on that edge.

## Timing
- REQ sampled to GNT: 1 cycle.
- GNT to first VALID Z: 1 cycle; VALID mirrors GNT delayed by 1.
- Grant length: exactly min(HOLD, cycles until REQ[owner] sampled low) cycles.
- Back-to-back grants: exactly one IDLE cycle with GNT=0000 between owners (break-before-make).
- HOLD=1: each grant is one cycle, then one IDLE cycle.
- Owner drops REQ on the same edge the counter hits 0: single end event, identical result.
- RST asserted mid-grant: all outputs cleared asynchronously; first grant after release starts search at requester 0.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins every arbitration, LAST unused (still reset, never updated).
- Undefined (default): round-robin as specified above.
- HOLD limit and break-before-make apply in both modes.

## Structure
- Package ch3_arb_pkg: state enum (IDLE, GRANT), N_REQ=4, SEL_W=2, CNT_W=4.
- Sub-module ch3_rr_pick: combinational picker, inputs REQ and LAST, outputs winner index and any-request flag; ARB_FIXED_PRIO_EN handled inside it.
- Top holds FSM, counter, LAST, and output registers; SEL feeds the CH2_4MUX select at integration.

## Test plan
- Reset: RST=1 mid-grant with REQ=1111 -> GNT=0000, SEL=00, Z=0, VALID=0, BUSY=0 immediately; after release first GNT=0001.
- Round robin: REQ=1111 held, HOLD=4 -> GNT sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001.
- Early release: REQ=0100 asserted, dropped after 2 grant cycles -> GNT=0100 for exactly 2 cycles, VALID 2 cycles lagging by 1.
- Data: owner 2, DIN[2] toggling 0,1,0 -> Z=0,1,0 one cycle later, VALID=1; DIN[0] toggling ignored.
- HOLD=1, REQ=0011 held -> GNT alternates 0001, 0000, 0010, 0000, 0001.
- ARB_FIXED_PRIO_EN defined, REQ=1010 held -> every grant goes to requester 1 (GNT=0010); requester 3 starved.
